// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter steering four valid/ready requesters through a 4:1 mux, bursts of up to MAXBURST beats.
// Grant one cycle after first request; data and handshake paths are combinational; stalls hold grant and count.

module mux4to1 #(
    parameter int WID = 4
) (
    input  logic         e,
    input  logic [1:0]   s,
    input  logic [WID:1] a,
    input  logic [WID:1] b,
    input  logic [WID:1] c,
    input  logic [WID:1] d,
    output logic [WID:1] y
);
    always_comb begin
        y = '0;
        if (e) begin
            case (s)
                2'd0:    y = a;
                2'd1:    y = b;
                2'd2:    y = c;
                default: y = d;
            endcase
        end
    end
endmodule

module mux4_rr_arbiter #(
    parameter int WID      = 4,
    parameter int MAXBURST = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   req_valid,
    input  logic [WID:1] req_data0,
    input  logic [WID:1] req_data1,
    input  logic [WID:1] req_data2,
    input  logic [WID:1] req_data3,
    output logic [3:0]   req_ready,
    output logic         out_valid,
    output logic [WID:1] out_data,
    input  logic         out_ready,
    output logic         mux_e,
    output logic [1:0]   mux_s,
    output logic [1:0]   gnt_idx
);
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;
    localparam logic [3:0] LP_LAST  = 4'(MAXBURST - 1);

    logic [0:0] r_state;
    logic [1:0] r_gnt_idx;
    logic [1:0] r_ptr;
    logic [3:0] r_beat_cnt;

    logic [0:0] w_nxt_state;
    logic [1:0] w_nxt_gnt;
    logic [1:0] w_nxt_ptr;
    logic [3:0] w_nxt_cnt;
    logic       w_grant;
    logic       w_cur_vld;
    logic       w_beat;
    logic       w_release;
    logic [1:0] w_ptr_rel;
    logic [2:0] w_pick_idle;
    logic [2:0] w_pick_rel;

    // Returns {found, index}: first valid requester scanning upward from start.
    function automatic logic [2:0] f_pick(input logic [1:0] start, input logic [3:0] vld);
        logic [2:0] res;
        logic [1:0] n;
        res = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            n = start + 2'(k);
            if (vld[n]) res = {1'b1, n};
        end
        return res;
    endfunction

    assign w_grant     = (r_state == ST_GRANT);
    assign w_cur_vld   = req_valid[r_gnt_idx];
    assign w_beat      = w_grant && w_cur_vld && out_ready && !rst;
    assign w_release   = w_grant && (!w_cur_vld || (w_beat && (r_beat_cnt == LP_LAST)));
    assign w_ptr_rel   = r_gnt_idx + 2'd1;
    assign w_pick_idle = f_pick(r_ptr, req_valid);
    assign w_pick_rel  = f_pick(w_ptr_rel, req_valid);

    // Reset gates the handshake so an in-flight burst cannot land one more beat.
    assign out_valid = w_grant && w_cur_vld && !rst;
    assign req_ready = (w_grant && out_ready && !rst) ? (4'b0001 << r_gnt_idx) : 4'b0000;
    assign mux_e     = w_grant;
    assign mux_s     = r_gnt_idx;
    assign gnt_idx   = r_gnt_idx;

    mux4to1 #(.WID(WID)) u_mux (
        .e (mux_e),
        .s (mux_s),
        .a (req_data0),
        .b (req_data1),
        .c (req_data2),
        .d (req_data3),
        .y (out_data)
    );

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_gnt   = r_gnt_idx;
        w_nxt_ptr   = r_ptr;
        w_nxt_cnt   = r_beat_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_idle[2]) begin
                    w_nxt_gnt   = w_pick_idle[1:0];
                    w_nxt_cnt   = 4'd0;
                    w_nxt_state = ST_GRANT;
                end
            end
            default: begin
                if (w_release) begin
                    // The released requester sits last in the new order, so it only wins when alone.
                    w_nxt_ptr = w_ptr_rel;
                    w_nxt_cnt = 4'd0;
                    if (w_pick_rel[2]) begin
                        w_nxt_gnt = w_pick_rel[1:0];
                    end else begin
                        w_nxt_state = ST_IDLE;
                    end
                end else if (w_beat) begin
                    w_nxt_cnt = r_beat_cnt + 4'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_gnt_idx  <= 2'd0;
            r_ptr      <= 2'd0;
            r_beat_cnt <= 4'd0;
        end else begin
            r_state    <= w_nxt_state;
            r_gnt_idx  <= w_nxt_gnt;
            r_ptr      <= w_nxt_ptr;
            r_beat_cnt <= w_nxt_cnt;
        end
    end
endmodule
